// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between a data-memory master and data_memory_ctrl.
// The slave modport is the controller side; the master modport is the requester side.
interface data_memory_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory with zero-on-reset clear sequence and registered reads.
// Define DMEM_BYTE_STROBE_EN to honour req_wstrb; otherwise every write updates the full word.
//
// state | meaning
// INIT  | clearing one word per cycle, busy=1, no requests accepted
// IDLE  | accepting reads and writes
// RESP  | read response held until the consumer takes it
module data_memory_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic               clk,
    input  logic               reset,
    data_memory_ctrl_if.slave  bus,
    output logic               busy
);
    localparam int NB = DATA_W / 8;

    generate
        if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
            $error("data_memory_ctrl: DATA_W must be a non-zero multiple of 8");
        end
        if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
            $error("data_memory_ctrl: DEPTH must be within 1..2**ADDR_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_cnt;
    logic                clr_last;
    logic                addr_in_range;
    logic                req_acc;
    logic                wr_acc;
    logic                rd_acc;
    logic [NB-1:0]       wstrb_eff;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    assign clr_last      = (clr_cnt == ADDR_W'(DEPTH - 1));
    assign addr_in_range = ({1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH));

`ifdef DMEM_BYTE_STROBE_EN
    assign wstrb_eff = bus.req_wstrb;
`else
    // Strobes are forced on so the port stays connected but has no effect.
    assign wstrb_eff = bus.req_wstrb | {NB{1'b1}};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (state == INIT) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        req_acc       = 1'b0;
        case (state)
            INIT: begin
                busy = 1'b1;
                if (clr_last) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                bus.req_ready = 1'b1;
                req_acc       = bus.req_valid;
                if (bus.req_valid && !bus.req_we) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    assign wr_acc = req_acc && bus.req_we && addr_in_range && !reset;
    assign rd_acc = req_acc && !bus.req_we;

    // The array has no reset; it is zeroed only by walking INIT.
    always_ff @(posedge clk) begin
        if (!reset && state == INIT) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_eff[b]) begin
                    mem[bus.req_addr][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Write-then-read needs no bypass: the write lands at the edge before the read samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (rd_acc) begin
            err_q   <= !addr_in_range;
            rdata_q <= addr_in_range ? mem[bus.req_addr] : '0;
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
